// File: rtl/noc_pkg.sv
// Shared encodings and defaults for the NoC input controller.
// Holds the handshake FSM state enums and the default packet width.
package noc_pkg;

  localparam int WIDTH_PACKET_DEFAULT = 14;

  typedef enum logic {
    I_IDLE,
    I_ACK
  } in_state_e;

  typedef enum logic [1:0] {
    O_IDLE,
    O_REQ,
    O_REL
  } out_state_e;

endpackage

// File: rtl/input_ctrl.sv
// 4-phase input demultiplexer: one upstream channel feeds two downstream
// channels through a one-entry buffer, with per-port delivered-packet counters.
module input_ctrl
  import noc_pkg::*;
#(
  parameter int WIDTH_packet = WIDTH_PACKET_DEFAULT,
  parameter int ROUTE_BIT    = 13,
  parameter int CNT_W        = 8
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    in_req,
  input  logic [WIDTH_packet-1:0] in_data,
  output logic                    in_ack,
  output logic                    out0_req,
  output logic                    out1_req,
  output logic [WIDTH_packet-1:0] out0_data,
  output logic [WIDTH_packet-1:0] out1_data,
  input  logic                    out0_ack,
  input  logic                    out1_ack,
  output logic [CNT_W-1:0]        cnt0,
  output logic [CNT_W-1:0]        cnt1
);

  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  in_state_e  in_state_q, in_state_d;
  out_state_e out_state_q, out_state_d;

  logic [WIDTH_packet-1:0] pkt_buf_q, pkt_buf_d;
  logic                    buf_valid_q, buf_valid_d;
  logic                    buf_set, buf_clr;
  logic                    armed_q, armed_d;
  logic                    in_ack_q, in_ack_d;

  logic                    sel_q, sel_d;
  logic                    out0_req_q, out0_req_d;
  logic                    out1_req_q, out1_req_d;
  logic [WIDTH_packet-1:0] out0_data_q, out0_data_d;
  logic [WIDTH_packet-1:0] out1_data_q, out1_data_d;
  logic [CNT_W-1:0]        cnt0_q, cnt0_d;
  logic [CNT_W-1:0]        cnt1_q, cnt1_d;

  logic route_sel;
  logic route_ack;
  logic cur_ack;

  assign route_sel = pkt_buf_q[ROUTE_BIT];
  assign route_ack = route_sel ? out1_ack : out0_ack;
  assign cur_ack   = sel_q ? out1_ack : out0_ack;

  // After reset a request still held high is stale; accept only once it has been seen low.
  assign armed_d = armed_q | ~in_req;

  always_comb begin
    in_state_d = in_state_q;
    in_ack_d   = in_ack_q;
    pkt_buf_d  = pkt_buf_q;
    buf_set    = 1'b0;
    case (in_state_q)
      I_IDLE: begin
        if (in_req && armed_q && !buf_valid_q) begin
          pkt_buf_d  = in_data;
          buf_set    = 1'b1;
          in_ack_d   = 1'b1;
          in_state_d = I_ACK;
        end
      end
      I_ACK: begin
        if (!in_req) begin
          in_ack_d   = 1'b0;
          in_state_d = I_IDLE;
        end
      end
      default: begin
        in_ack_d   = 1'b0;
        in_state_d = I_IDLE;
      end
    endcase
  end

  always_comb begin
    out_state_d = out_state_q;
    sel_d       = sel_q;
    buf_clr     = 1'b0;
    out0_req_d  = out0_req_q;
    out1_req_d  = out1_req_q;
    out0_data_d = out0_data_q;
    out1_data_d = out1_data_q;
    cnt0_d      = cnt0_q;
    cnt1_d      = cnt1_q;
    case (out_state_q)
      O_IDLE: begin
        // A still-high ack on the target port is a previous phase; wait for it to drop.
        if (buf_valid_q && !route_ack) begin
          sel_d       = route_sel;
          buf_clr     = 1'b1;
          out_state_d = O_REQ;
          if (route_sel) begin
            out1_data_d = pkt_buf_q;
            out1_req_d  = 1'b1;
          end else begin
            out0_data_d = pkt_buf_q;
            out0_req_d  = 1'b1;
          end
        end
      end
      O_REQ: begin
        if (cur_ack) begin
          if (sel_q) out1_req_d = 1'b0;
          else       out0_req_d = 1'b0;
          out_state_d = O_REL;
        end
      end
      O_REL: begin
        if (!cur_ack) begin
          if (sel_q) cnt1_d = cnt1_q + CNT_ONE;
          else       cnt0_d = cnt0_q + CNT_ONE;
          out_state_d = O_IDLE;
        end
      end
      default: begin
        out0_req_d  = 1'b0;
        out1_req_d  = 1'b0;
        out_state_d = O_IDLE;
      end
    endcase
  end

  // Set and clear never coincide: set needs valid low, clear needs valid high.
  assign buf_valid_d = (buf_valid_q | buf_set) & ~buf_clr;

  always_ff @(posedge clk) begin
    if (rst) begin
      in_state_q  <= I_IDLE;
      out_state_q <= O_IDLE;
      pkt_buf_q   <= '0;
      buf_valid_q <= 1'b0;
      armed_q     <= ~in_req;
      in_ack_q    <= 1'b0;
      sel_q       <= 1'b0;
      out0_req_q  <= 1'b0;
      out1_req_q  <= 1'b0;
      out0_data_q <= '0;
      out1_data_q <= '0;
      cnt0_q      <= '0;
      cnt1_q      <= '0;
    end else begin
      in_state_q  <= in_state_d;
      out_state_q <= out_state_d;
      pkt_buf_q   <= pkt_buf_d;
      buf_valid_q <= buf_valid_d;
      armed_q     <= armed_d;
      in_ack_q    <= in_ack_d;
      sel_q       <= sel_d;
      out0_req_q  <= out0_req_d;
      out1_req_q  <= out1_req_d;
      out0_data_q <= out0_data_d;
      out1_data_q <= out1_data_d;
      cnt0_q      <= cnt0_d;
      cnt1_q      <= cnt1_d;
    end
  end

  assign in_ack    = in_ack_q;
  assign out0_req  = out0_req_q;
  assign out1_req  = out1_req_q;
  assign out0_data = out0_data_q;
  assign out1_data = out1_data_q;
  assign cnt0      = cnt0_q;
  assign cnt1      = cnt1_q;

endmodule

// File: tb/tb_input_ctrl.sv
// Scoreboard bench for input_ctrl: directed packets with hand-computed routing,
// downstream responders with programmable ack delay, and a popping monitor.
module tb_input_ctrl;

  localparam int W = 14;

  logic         clk = 1'b0;
  logic         rst;
  logic         inReq;
  logic [W-1:0] inData;
  logic         inAck;
  logic         out0Req, out1Req;
  logic [W-1:0] out0Data, out1Data;
  logic         out0Ack, out1Ack;
  logic [7:0]   cnt0, cnt1;

  int errors = 0;
  int checks = 0;

  logic [W-1:0] exp0[$];
  logic [W-1:0] exp1[$];

  int ackDelay0 = 0;
  int ackDelay1 = 0;
  bit hold1 = 1'b0;
  int delivered0 = 0;
  int delivered1 = 0;

  always #5 clk = ~clk;

  input_ctrl #(.WIDTH_packet(W), .ROUTE_BIT(13), .CNT_W(8)) dut (
    .clk(clk), .rst(rst),
    .in_req(inReq), .in_data(inData), .in_ack(inAck),
    .out0_req(out0Req), .out1_req(out1Req),
    .out0_data(out0Data), .out1_data(out1Data),
    .out0_ack(out0Ack), .out1_ack(out1Ack),
    .cnt0(cnt0), .cnt1(cnt1)
  );

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", name, actual, expected);
    end
  endtask

  task automatic timeoutFail(input string name);
    checks++;
    errors++;
    $display("[TB] FAIL %s: timed out, got no response expected a handshake", name);
  endtask

  task automatic waitAck(input logic level, input string name);
    int n = 0;
    while (inAck !== level && n < 300) begin
      @(negedge clk);
      n++;
    end
    if (inAck !== level) timeoutFail(name);
  endtask

  task automatic pushExpected(input logic [W-1:0] d);
    if (d[13]) exp1.push_back(d);
    else       exp0.push_back(d);
  endtask

  task automatic raiseReq(input logic [W-1:0] d);
    inData = d;
    inReq  = 1'b1;
    pushExpected(d);
    waitAck(1'b1, "in_ack rise");
  endtask

  task automatic dropReq();
    inReq = 1'b0;
    waitAck(1'b0, "in_ack fall");
  endtask

  task automatic applyStimulus(input logic [W-1:0] d);
    raiseReq(d);
    dropReq();
  endtask

  task automatic waitQuiet();
    int n = 0;
    while (!(exp0.size() == 0 && exp1.size() == 0 && !out0Req && !out1Req &&
             !out0Ack && !out1Ack && !inAck) && n < 600) begin
      @(negedge clk);
      n++;
    end
    if (n >= 600) timeoutFail("drain");
    repeat (2) @(negedge clk);
  endtask

  // Downstream port 0 responder.
  initial begin
    int dly = 0;
    bit acked = 1'b0;
    out0Ack = 1'b0;
    forever begin
      @(negedge clk);
      if (rst) begin
        out0Ack = 1'b0; dly = 0; acked = 1'b0; delivered0 = 0;
      end else if (out0Req && !out0Ack) begin
        if (dly >= ackDelay0) begin out0Ack = 1'b1; acked = 1'b1; dly = 0; end
        else dly++;
      end else if (!out0Req && out0Ack) begin
        out0Ack = 1'b0;
        if (acked) delivered0++;
        acked = 1'b0;
      end
    end
  end

  // Downstream port 1 responder; hold1 forces a stray ack.
  initial begin
    int dly = 0;
    bit acked = 1'b0;
    out1Ack = 1'b0;
    forever begin
      @(negedge clk);
      if (rst) begin
        out1Ack = 1'b0; dly = 0; acked = 1'b0; delivered1 = 0;
      end else if (hold1) begin
        out1Ack = 1'b1;
      end else if (out1Req && !out1Ack) begin
        if (dly >= ackDelay1) begin out1Ack = 1'b1; acked = 1'b1; dly = 0; end
        else dly++;
      end else if (!out1Req && out1Ack) begin
        out1Ack = 1'b0;
        if (acked) delivered1++;
        acked = 1'b0;
      end
    end
  end

  // Monitor: each new downstream request pops the oldest expected packet of that port.
  initial begin
    bit prev0 = 1'b0;
    bit prev1 = 1'b0;
    logic [W-1:0] e;
    forever begin
      @(negedge clk);
      if (rst) begin
        exp0.delete(); exp1.delete();
        prev0 = 1'b0; prev1 = 1'b0;
      end else begin
        if (out0Req && !prev0) begin
          if (exp0.size() == 0) begin
            checks++; errors++;
            $display("[TB] FAIL out0 unexpected: got 0x%0h expected no packet", out0Data);
          end else begin
            e = exp0.pop_front();
            checkOutput("out0 data order", 32'(out0Data), 32'(e));
            checkOutput("out1 req idle during out0", 32'(out1Req), 32'd0);
          end
        end
        if (out1Req && !prev1) begin
          if (exp1.size() == 0) begin
            checks++; errors++;
            $display("[TB] FAIL out1 unexpected: got 0x%0h expected no packet", out1Data);
          end else begin
            e = exp1.pop_front();
            checkOutput("out1 data order", 32'(out1Data), 32'(e));
            checkOutput("out0 req idle during out1", 32'(out0Req), 32'd0);
          end
        end
        prev0 = out0Req;
        prev1 = out1Req;
      end
    end
  end

  initial begin
    #800000;
    $display("[TB] FAIL watchdog: got no end of test expected $finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    bit sawAck;
    bit sawReq1;
    int n;
    logic [W-1:0] d;

    rst = 1'b1; inReq = 1'b0; inData = '0;
    repeat (3) @(negedge clk);
    checkOutput("reset in_ack", 32'(inAck), 32'd0);
    checkOutput("reset out0_req", 32'(out0Req), 32'd0);
    checkOutput("reset out1_req", 32'(out1Req), 32'd0);
    checkOutput("reset out0_data", 32'(out0Data), 32'd0);
    checkOutput("reset out1_data", 32'(out1Data), 32'd0);
    checkOutput("reset cnt0", 32'(cnt0), 32'd0);
    checkOutput("reset cnt1", 32'(cnt1), 32'd0);
    rst = 1'b0;
    @(negedge clk);

    // First packet with latency checks on the exact cycles.
    inData = 14'h17C0; inReq = 1'b1; pushExpected(14'h17C0);
    @(negedge clk);
    checkOutput("latency in_ack after k", 32'(inAck), 32'd1);
    checkOutput("latency out0_req not yet at k", 32'(out0Req), 32'd0);
    @(negedge clk);
    checkOutput("latency out0_req after k+1", 32'(out0Req), 32'd1);
    checkOutput("first out0_data", 32'(out0Data), 32'h17C0);
    dropReq();
    waitQuiet();
    checkOutput("cnt0 after 0x17C0", 32'(cnt0), 32'd1);
    checkOutput("cnt1 after 0x17C0", 32'(cnt1), 32'd0);
    checkOutput("out1_data untouched", 32'(out1Data), 32'd0);
    checkOutput("model deliveries port0", 32'(delivered0), 32'd1);

    applyStimulus(14'h2820);
    waitQuiet();
    checkOutput("out1_data 0x2820", 32'(out1Data), 32'h2820);
    checkOutput("cnt1 after 0x2820", 32'(cnt1), 32'd1);
    applyStimulus(14'h1ABE);
    applyStimulus(14'h313E);
    waitQuiet();
    checkOutput("cnt0 two", 32'(cnt0), 32'd2);
    checkOutput("cnt1 two", 32'(cnt1), 32'd2);
    checkOutput("out0_data 0x1ABE", 32'(out0Data), 32'h1ABE);
    checkOutput("out1_data 0x313E", 32'(out1Data), 32'h313E);

    // Stray ack on port 1 stalls the buffer and backpressures upstream.
    hold1 = 1'b1;
    @(negedge clk);
    applyStimulus(14'h313E);
    inData = 14'h0123; inReq = 1'b1; pushExpected(14'h0123);
    sawAck = 1'b0; sawReq1 = 1'b0;
    repeat (8) begin
      @(negedge clk);
      if (inAck) sawAck = 1'b1;
      if (out1Req) sawReq1 = 1'b1;
    end
    checkOutput("in_ack held off while buffer full", 32'(sawAck), 32'd0);
    checkOutput("out1_req held off by stray ack", 32'(sawReq1), 32'd0);
    hold1 = 1'b0;
    waitAck(1'b1, "in_ack after stray ack released");
    dropReq();
    waitQuiet();
    checkOutput("cnt0 three", 32'(cnt0), 32'd3);
    checkOutput("cnt1 three", 32'(cnt1), 32'd3);
    checkOutput("out0_data 0x0123", 32'(out0Data), 32'h0123);

    // Slow port 0: third packet only enters once the second leaves the buffer.
    ackDelay0 = 5;
    applyStimulus(14'h0AAA);
    applyStimulus(14'h0555);
    raiseReq(14'h1234);
    checkOutput("third accepted while second in flight: out0_req", 32'(out0Req), 32'd1);
    checkOutput("third accepted while second in flight: out0_data", 32'(out0Data), 32'h0555);
    dropReq();
    waitQuiet();
    checkOutput("cnt0 six", 32'(cnt0), 32'd6);

    // Reset in the middle of a downstream handshake.
    ackDelay0 = 20;
    applyStimulus(14'h17C0);
    n = 0;
    while (!out0Req && n < 50) begin @(negedge clk); n++; end
    if (!out0Req) timeoutFail("out0_req before mid reset");
    rst = 1'b1;
    @(negedge clk);
    checkOutput("mid reset in_ack", 32'(inAck), 32'd0);
    checkOutput("mid reset out0_req", 32'(out0Req), 32'd0);
    checkOutput("mid reset out1_req", 32'(out1Req), 32'd0);
    checkOutput("mid reset out0_data", 32'(out0Data), 32'd0);
    checkOutput("mid reset out1_data", 32'(out1Data), 32'd0);
    checkOutput("mid reset cnt0", 32'(cnt0), 32'd0);
    checkOutput("mid reset cnt1", 32'(cnt1), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    ackDelay0 = 0;
    @(negedge clk);
    applyStimulus(14'h17C0);
    waitQuiet();
    checkOutput("post reset cnt0", 32'(cnt0), 32'd1);
    checkOutput("post reset out0_data", 32'(out0Data), 32'h17C0);

    // 255 more packets to port 0 bring the 8-bit counter to 256 -> 0.
    for (int i = 1; i < 256; i++) begin
      d = W'(i * 37) & 14'h1FFF;
      applyStimulus(d);
    end
    waitQuiet();
    checkOutput("cnt0 wrap", 32'(cnt0), 32'd0);
    checkOutput("cnt1 after wrap run", 32'(cnt1), 32'd0);
    checkOutput("out0_data last of wrap run", 32'(out0Data), 32'((255 * 37) & 'h1FFF));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/input_ctrl.md
INPUT_CTRL -- requirements
Module: input_ctrl

Interface
REQ-001 Parameter WIDTH_packet, default 14, is the packet width in bits.
REQ-002 Parameter ROUTE_BIT, default 13, is the packet bit index that selects the output port.
REQ-003 Parameter CNT_W, default 8, is the width of each per-port delivered-packet counter.
REQ-004 Port clk, input, 1, is the single clock; all logic SHALL be rising-edge.
REQ-005 Port rst, input, 1, is a synchronous, active-high reset.
REQ-006 Port in_req, input, 1, is the 4-phase request from the upstream sender.
REQ-007 Port in_data, input, WIDTH_packet, is the upstream packet, stable while in_req=1.
REQ-008 Port in_ack, output, 1, is the 4-phase acknowledge to upstream.
REQ-009 Ports out0_req and out1_req, output, 1 each, are the 4-phase requests to the downstream ports.
REQ-010 Ports out0_data and out1_data, output, WIDTH_packet each, are the downstream packets.
REQ-011 Ports out0_ack and out1_ack, input, 1 each, are the downstream acknowledges.
REQ-012 Ports cnt0 and cnt1, output, CNT_W each, count packets fully delivered per port.
REQ-013 All inputs SHALL be treated as synchronous to clk; the block contains no synchronizers.

Function
REQ-014 The block SHALL demultiplex one 4-phase input channel to two 4-phase output channels through a one-entry buffer (buf, buf_valid).
REQ-015 Input FSM, state I_IDLE: if in_req=1 and registered buf_valid=0, the block SHALL capture in_data into buf, set buf_valid=1 and in_ack=1, and go to I_ACK.
REQ-016 Input FSM, state I_ACK: when in_req=0, the block SHALL set in_ack=0 and go to I_IDLE.
REQ-017 Output FSM, state O_IDLE: if buf_valid=1, the block SHALL set sel=buf[ROUTE_BIT].
  - If the selected ack=0: load outSEL_data=buf, set outSEL_req=1, clear buf_valid, go to O_REQ.
  - Otherwise stay in O_IDLE.
REQ-018 Output FSM, state O_REQ: when the selected ack=1, the block SHALL set outSEL_req=0 and go to O_REL.
REQ-019 Output FSM, state O_REL: when the selected ack=0, the block SHALL increment cntSEL and go to O_IDLE.
REQ-020 Latency: with in_req first sampled high at edge k, in_ack SHALL rise after edge k and outSEL_req SHALL rise after edge k+1.
REQ-021 Simultaneous buffer release and new input request: the input FSM SHALL see registered buf_valid=1 and SHALL capture no earlier than the next edge; no packet is lost or duplicated.
REQ-022 The unselected output's req SHALL stay 0 and its data SHALL hold its last value.
REQ-023 outX_data SHALL not change while outX_req=1.
REQ-024 An ack without a matching req, or on the unselected port, SHALL be ignored.
REQ-025 Counters SHALL wrap modulo 2^CNT_W with no saturation.
REQ-026 Packet order per output port SHALL equal arrival order.

Reset
REQ-027 While rst=1 at an edge, the block SHALL set:
  - in_ack, out0_req, out1_req = 0;
  - out0_data, out1_data, buf = 0;
  - buf_valid = 0;
  - cnt0, cnt1 = 0;
  - FSMs to I_IDLE and O_IDLE.
REQ-028 Reset mid-handshake SHALL discard any buffered or in-flight packet; after release, the block SHALL wait for a fresh in_req rising phase.

Structure
REQ-029 The state enums (I_IDLE, I_ACK, O_IDLE, O_REQ, O_REL) and the WIDTH_packet default SHALL live in the shared package noc_pkg.
REQ-030 The block SHALL be a single module with no sub-module; the two output channels share one output FSM.

Verification
REQ-031 Send 0x17C0 (bit13=0) -> appears on out0_data, out0_req pulses once, cnt0=1, out1 idle.
REQ-032 Send 0x2820 (bit13=1) -> appears on out1_data, cnt1=1; then 0x1ABE -> out0, 0x313E -> out1, counts 2/2.
REQ-033 Hold out1_ack=1 while sending 0x313E -> out1_req stays 0 and in_ack stays 0 for a second request until out1_ack falls, then delivery completes.
REQ-034 Back-to-back sends with out0_ack delayed 5 cycles -> second packet accepted only after buf frees, and order is preserved.
REQ-035 Assert rst while out0_req=1 -> next edge all outputs 0, counters 0; the subsequent packet 0x17C0 is delivered normally.
REQ-036 Deliver 256 packets to out0 with CNT_W=8 -> cnt0 wraps to 0.
